// File: rtl/vga_timing_monitor.sv
// Receive-side VGA sync checker: rebuilds pixel position from hsync/vsync and checks line/frame geometry.
// Optional saturating error counter on port err_count when VGA_MON_ERRCNT_EN is defined.
module vga_timing_monitor #(
  parameter int H_VIZ       = 640,
  parameter int H_PULSE     = 96,
  parameter int H_BP        = 48,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 800,
  parameter int V_VIZ       = 480,
  parameter int V_PULSE     = 2,
  parameter int V_BP        = 33,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_vga,
  input  logic        rst_vga,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [9:0]  h_pos,
  output logic [9:0]  v_pos,
  output logic        visible,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        locked,
  output logic        err,
  output logic [1:0]  err_code
`ifdef VGA_MON_ERRCNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam logic [9:0] POS_MAX      = 10'h3FF;
  localparam logic [9:0] H_PULSE_LAST = 10'(H_PULSE - 1);
  localparam logic [9:0] H_LAST       = 10'(H_SYNC - 1);
  localparam logic [9:0] H_WDOG       = 10'(H_SYNC + H_FP);
  localparam logic [9:0] H_ACT_START  = 10'(H_PULSE + H_BP);
  localparam logic [9:0] H_ACT_END    = 10'(H_SYNC - H_FP);
  localparam logic [9:0] V_LAST       = 10'(V_SYNC - 1);
  localparam logic [9:0] V_ACT_START  = 10'(V_PULSE + V_BP);
  localparam logic [9:0] V_ACT_END    = 10'(V_SYNC - V_FP);
  localparam logic [3:0] LOCK_N       = 4'(LOCK_FRAMES);

  if ((H_PULSE + H_BP + H_VIZ + H_FP != H_SYNC) ||
      (V_PULSE + V_BP + V_VIZ + V_FP != V_SYNC) ||
      (LOCK_FRAMES < 1) || (LOCK_FRAMES > 15)) begin : g_param_check
    $error("vga_timing_monitor: inconsistent timing parameters");
  end

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t     state_q, state_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic       hs_q, vs_q, v_pend;
  logic       hfall, hrise, vfall, frame_start, armed;
  logic       e_line, e_hsync, e_frame, any_err;
  logic [1:0] code_d;
  logic       h_in_win, v_in_win;

  assign hfall       = hs_q & ~hsync_in;
  assign hrise       = ~hs_q & hsync_in;
  assign vfall       = vs_q & ~vsync_in;
  assign frame_start = hfall & (vfall | v_pend);
  assign armed       = (state_q != SEARCH);

  // The watchdog fires only on the single cycle h_pos passes H_WDOG, so a stall reports once.
  assign e_line  = armed & ((hfall & (h_pos != H_LAST)) | (~hfall & (h_pos == H_WDOG)));
  assign e_hsync = armed & hrise & (h_pos != H_PULSE_LAST);
  assign e_frame = armed & frame_start & (v_pos != V_LAST);
  assign any_err = e_line | e_hsync | e_frame;

  always_comb begin
    code_d = 2'b11;
    if (e_line)
      code_d = 2'b01;
    else if (e_hsync)
      code_d = 2'b10;
  end

  always_ff @(posedge clk_vga or posedge rst_vga) begin
    if (rst_vga) begin
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      v_pend   <= 1'b0;
      h_pos    <= '0;
      v_pos    <= '0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      hs_q <= hsync_in;
      vs_q <= vsync_in;
      if (hfall)
        h_pos <= '0;
      else if (h_pos != POS_MAX)
        h_pos <= h_pos + 10'd1;
      // A vsync fall between hsync falls is held until the next line start consumes it.
      if (hfall) begin
        v_pend <= 1'b0;
        if (vfall | v_pend)
          v_pos <= '0;
        else if (v_pos != POS_MAX)
          v_pos <= v_pos + 10'd1;
      end else if (vfall) begin
        v_pend <= 1'b1;
      end
      err <= any_err;
      if (any_err)
        err_code <= code_d;
    end
  end

  always_ff @(posedge clk_vga or posedge rst_vga) begin
    if (rst_vga) begin
      state_q    <= SEARCH;
      good_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      SEARCH: begin
        if (frame_start) begin
          state_d    = CHECK;
          good_cnt_d = '0;
        end
      end
      CHECK: begin
        if (any_err) begin
          state_d = SEARCH;
        end else if (frame_start) begin
          good_cnt_d = good_cnt_q + 4'd1;
          if (good_cnt_q + 4'd1 == LOCK_N)
            state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (any_err)
          state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  assign locked   = (state_q == LOCKED);
  assign h_in_win = (h_pos >= H_ACT_START) && (h_pos < H_ACT_END);
  assign v_in_win = (v_pos >= V_ACT_START) && (v_pos < V_ACT_END);
  assign visible  = locked & h_in_win & v_in_win;
  assign pix_x    = visible ? (h_pos - H_ACT_START) : '0;
  assign pix_y    = visible ? (v_pos - V_ACT_START) : '0;

`ifdef VGA_MON_ERRCNT_EN
  always_ff @(posedge clk_vga or posedge rst_vga) begin
    if (rst_vga)
      err_count <= '0;
    else if (any_err && (err_count != 16'hFFFF))
      err_count <= err_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Randomized bench for vga_timing_monitor on a shrunken raster, checked every cycle against a
// duration-based reference model (clocks since line start, lines since frame start, trust level).
module tb_vga_timing_monitor;

  localparam int H_VIZ = 16, H_PULSE = 4, H_BP = 3, H_FP = 2, H_SYNC = 25;
  localparam int V_VIZ = 6,  V_PULSE = 2, V_BP = 2, V_FP = 1, V_SYNC = 11;
  localparam int LOCK_FRAMES = 2;
  localparam int FRAME = H_SYNC * V_SYNC;

  logic       clk_vga = 1'b0;
  logic       rst_vga, hsync_in, vsync_in;
  logic [9:0] h_pos, v_pos, pix_x, pix_y;
  logic       visible, locked, err;
  logic [1:0] err_code;
`ifdef VGA_MON_ERRCNT_EN
  logic [15:0] err_count;
  int          m_errcnt;
`endif

  vga_timing_monitor #(
    .H_VIZ(H_VIZ), .H_PULSE(H_PULSE), .H_BP(H_BP), .H_FP(H_FP), .H_SYNC(H_SYNC),
    .V_VIZ(V_VIZ), .V_PULSE(V_PULSE), .V_BP(V_BP), .V_FP(V_FP), .V_SYNC(V_SYNC),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk_vga(clk_vga), .rst_vga(rst_vga), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .h_pos(h_pos), .v_pos(v_pos), .visible(visible), .pix_x(pix_x), .pix_y(pix_y),
    .locked(locked), .err(err),
`ifdef VGA_MON_ERRCNT_EN
    .err_count(err_count),
`endif
    .err_code(err_code)
  );

  always #5 clk_vga = ~clk_vga;

  int checks = 0, errors = 0;
  int cyc = 0, reset_cyc = 0, lock_cyc = -1, err_pulses = 0;
  // Reference model state: trust -1 = searching, 0..LOCK_FRAMES-1 = good frames so far, LOCK_FRAMES = locked.
  int   m_last_fall, m_vcnt, m_trust, m_code;
  logic m_hs, m_vs, m_pend, m_err;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic doReset();
    rst_vga = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    repeat (2) @(posedge clk_vga);
    #1;
    rst_vga = 1'b0;
    m_hs = 1'b0; m_vs = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    m_vcnt = 0; m_trust = -1; m_code = 0;
`ifdef VGA_MON_ERRCNT_EN
    m_errcnt = 0;
`endif
    m_last_fall = cyc - 1;
    reset_cyc = cyc;
    lock_cyc = -1;
  endtask

  // One pixel clock: drive inputs, advance the model over the edge, compare every output.
  task automatic step(input logic hs, input logic vs);
    logic hf, hr, vf, fs, armed, e_line, e_hs, e_fr, lock_exp, vis_exp;
    int since, h_exp, v_exp, v_now;
    hsync_in = hs; vsync_in = vs;
    @(posedge clk_vga);
    #1;
    hf = m_hs & ~hs; hr = ~m_hs & hs; vf = m_vs & ~vs;
    since = cyc - m_last_fall;
    v_now = (m_vcnt > 1023) ? 1023 : m_vcnt;
    armed = (m_trust >= 0);
    fs = hf & (vf | m_pend);
    e_line = armed & ((hf & (since != H_SYNC)) | (~hf & (since - 1 == H_SYNC + H_FP)));
    e_hs   = armed & hr & (since != H_PULSE);
    e_fr   = armed & fs & (v_now != V_SYNC - 1);
    m_err  = e_line | e_hs | e_fr;
    if (m_err) begin
      m_code = e_line ? 1 : (e_hs ? 2 : 3);
`ifdef VGA_MON_ERRCNT_EN
      if (m_errcnt < 65535) m_errcnt++;
`endif
      m_trust = -1;
    end else if (fs) begin
      m_trust = (m_trust < LOCK_FRAMES) ? m_trust + 1 : LOCK_FRAMES;
    end
    if (hf) begin
      m_last_fall = cyc;
      m_vcnt = fs ? 0 : ((m_vcnt < 2000) ? m_vcnt + 1 : m_vcnt);
      m_pend = 1'b0;
    end else if (vf) begin
      m_pend = 1'b1;
    end
    m_hs = hs; m_vs = vs;
    cyc++;
    h_exp = cyc - m_last_fall - 1;
    if (h_exp > 1023) h_exp = 1023;
    v_exp = (m_vcnt > 1023) ? 1023 : m_vcnt;
    lock_exp = (m_trust == LOCK_FRAMES);
    vis_exp = lock_exp && h_exp >= H_PULSE + H_BP && h_exp < H_SYNC - H_FP
                       && v_exp >= V_PULSE + V_BP && v_exp < V_SYNC - V_FP;
    checkOutput("h_pos", h_pos, h_exp);
    checkOutput("v_pos", v_pos, v_exp);
    checkOutput("locked", locked, lock_exp);
    checkOutput("visible", visible, vis_exp);
    checkOutput("pix_x", pix_x, vis_exp ? h_exp - (H_PULSE + H_BP) : 0);
    checkOutput("pix_y", pix_y, vis_exp ? v_exp - (V_PULSE + V_BP) : 0);
    checkOutput("err", err, m_err);
    checkOutput("err_code", err_code, m_code);
`ifdef VGA_MON_ERRCNT_EN
    checkOutput("err_count", err_count, m_errcnt);
`endif
    if (err === 1'b1) err_pulses++;
    if (locked === 1'b1 && lock_cyc < 0) lock_cyc = cyc - reset_cyc;
  endtask

  // One frame of n_lines; vsync of the next frame falls voff_next clocks before its first hsync fall.
  task automatic applyStimulus(input int n_lines, input int voff_next, input bit faults);
    int len, pw;
    logic vs;
    for (int ln = 0; ln < n_lines; ln++) begin
      len = H_SYNC;
      pw  = H_PULSE;
      if (faults && $urandom_range(59, 0) == 0) begin
        case ($urandom_range(3, 0))
          0:       len = H_SYNC - 1;
          1:       len = H_SYNC + 1;
          2:       len = H_SYNC + 4;
          default: len = H_SYNC - 3;
        endcase
      end
      if (faults && $urandom_range(59, 0) == 0)
        pw = ($urandom_range(1, 0) == 1) ? H_PULSE + 1 : H_PULSE - 1;
      for (int i = 0; i < len; i++) begin
        vs = !((ln < V_PULSE) || (ln == n_lines - 1 && i >= len - voff_next));
        step(i >= pw, vs);
      end
    end
  endtask

  task automatic waitLock(input string tag);
    for (int f = 0; f < 8 && locked !== 1'b1; f++)
      applyStimulus(V_SYNC, $urandom_range(3, 0), 1'b0);
    checkOutput(tag, locked, 1);
  endtask

  initial begin
    int p0, n;
    rst_vga = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    #3;
    checkOutput("reset_h_pos", h_pos, 0);
    checkOutput("reset_locked", locked, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_err_code", err_code, 0);
    doReset();

    for (int f = 0; f < 4; f++) applyStimulus(V_SYNC, $urandom_range(3, 0), 1'b0);
    checkOutput("lock_within_3_frames", (lock_cyc >= 0 && lock_cyc <= 3 * FRAME + 2), 1);
    p0 = err_pulses;
    for (int f = 0; f < 10; f++) applyStimulus(V_SYNC, $urandom_range(3, 0), 1'b0);
    checkOutput("locked_clean_err_count", err_pulses - p0, 0);
    checkOutput("locked_after_clean", locked, 1);

    for (int f = 0; f < 100; f++) begin
      n = V_SYNC;
      if ($urandom_range(9, 0) == 0) n = ($urandom_range(1, 0) == 1) ? V_SYNC + 1 : V_SYNC - 1;
      applyStimulus(n, $urandom_range(3, 0), 1'b1);
    end

    waitLock("relock_after_random");
    p0 = err_pulses;
    for (int i = 0; i < 1100; i++) step(1'b1, 1'b1);
    checkOutput("stall_single_err", err_pulses - p0, 1);
    checkOutput("stall_err_code", err_code, 1);
    checkOutput("stall_h_sat", h_pos, 1023);

    waitLock("relock_after_stall");
    for (int i = 0; i < 10; i++) step(i >= H_PULSE, 1'b0);
    #2;
    rst_vga = 1'b1;
    #1;
    checkOutput("async_rst_h_pos", h_pos, 0);
    checkOutput("async_rst_v_pos", v_pos, 0);
    checkOutput("async_rst_locked", locked, 0);
    checkOutput("async_rst_err_code", err_code, 0);
    checkOutput("async_rst_visible", visible, 0);
    doReset();
    for (int f = 0; f < 4; f++) applyStimulus(V_SYNC, $urandom_range(3, 0), 1'b0);
    checkOutput("relock_after_reset", (lock_cyc >= 0 && lock_cyc <= 3 * FRAME + 2), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
